// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-hazard definitions: Tuse/Tnew encodings, mult/div latencies and
// the scoreboard slot payload used by the stall controller and the decoder.
package hazard_stall_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned T_W   = 2;

    localparam logic [T_W-1:0] TUSE_NONE = 2'd3;
    localparam logic [T_W-1:0] TNEW_LINK = 2'd0;
    localparam logic [T_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [T_W-1:0] TNEW_LOAD = 2'd2;

    localparam int unsigned MULT_CYCLES_DEFAULT = 5;
    localparam int unsigned DIV_CYCLES_DEFAULT  = 10;
    localparam int unsigned CNT_W_DEFAULT       = 4;

    typedef struct packed {
        logic [REG_W-1:0] wa;
        logic [T_W-1:0]   tnew;
    } sb_slot_t;

    // Tnew ages by one each stage and bottoms out once the result exists
    function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
        return (t == TNEW_LINK) ? TNEW_LINK : t - T_W'(1);
    endfunction

    function automatic logic src_hazard(input logic [REG_W-1:0] src,
                                        input logic [T_W-1:0]   tuse,
                                        input sb_slot_t         e_slot,
                                        input sb_slot_t         m_slot);
        logic e_hit;
        logic m_hit;
        e_hit = (e_slot.wa == src) && (e_slot.tnew > tuse);
        m_hit = (m_slot.wa == src) && (m_slot.tnew > tuse);
        return (src != '0) && (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Mult/div occupancy countdown: loads the unit latency on issue, then drains to zero.
module md_busy_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for F/D and D/E: E/M destination scoreboard checked against
// D-stage sources by Tuse, plus mult/div unit occupancy.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic [T_W-1:0]   d_tuse_rs,
    input  logic [T_W-1:0]   d_tuse_rt,
    input  logic [REG_W-1:0] d_wa,
    input  logic [T_W-1:0]   d_tnew,
    input  logic             d_md_start,
    input  logic             d_md_div,
    input  logic             d_md_use,
    input  logic             flush_req,
    output logic             stall,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_clr,
    output logic             de_clr,
    output logic             md_busy,
    output logic [REG_W-1:0] e_wa,
    output logic [REG_W-1:0] m_wa,
    output logic [T_W-1:0]   e_tnew,
    output logic [T_W-1:0]   m_tnew
);

    sb_slot_t         e_slot;
    sb_slot_t         m_slot;
    logic [CNT_W-1:0] md_cnt;
    logic             hz_rs;
    logic             hz_rt;
    logic             md_hold;
    logic             transfer;
    logic             md_load;
    logic [CNT_W-1:0] md_load_val;

    // Hazard decision is purely combinational so the hold takes effect this cycle
    always_comb begin
        hz_rs    = src_hazard(d_rs, d_tuse_rs, e_slot, m_slot);
        hz_rt    = src_hazard(d_rt, d_tuse_rt, e_slot, m_slot);
        md_hold  = d_md_use && (md_cnt != '0);
        stall    = d_valid && !flush_req && (hz_rs || hz_rt || md_hold);
        transfer = d_valid && !stall && !flush_req;
    end

    assign pc_en  = !stall;
    assign fd_en  = !stall;
    assign fd_clr = flush_req;
    assign de_clr = stall || flush_req;

    assign e_wa   = e_slot.wa;
    assign e_tnew = e_slot.tnew;
    assign m_wa   = m_slot.wa;
    assign m_tnew = m_slot.tnew;

    // Shadow of the E and M pipeline registers; a bubble or flush enters E as {0,0}
    always_ff @(posedge clk) begin
        if (reset) begin
            e_slot <= '0;
            m_slot <= '0;
        end else begin
            m_slot.wa   <= e_slot.wa;
            m_slot.tnew <= sat_dec(e_slot.tnew);
            if (transfer) begin
                e_slot.wa   <= d_wa;
                e_slot.tnew <= d_tnew;
            end else begin
                e_slot <= '0;
            end
        end
    end

    assign md_load     = transfer && d_md_start;
    assign md_load_val = d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_busy_counter #(
        .CNT_W (CNT_W)
    ) u_md_busy_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val (md_load_val),
        .cnt      (md_cnt),
        .busy     (md_busy)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed vector table, mult/div/reset sequences and
// randomized traffic against a timeline model of in-flight instructions.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_start, d_md_div, d_md_use, flush_req;
    logic       stall, pc_en, fd_en, fd_clr, de_clr, md_busy;
    logic [4:0] e_wa, m_wa;
    logic [1:0] e_tnew, m_tnew;

    int total = 0;
    int bad   = 0;

    hazard_stall_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_tuse_rs  (d_tuse_rs),
        .d_tuse_rt  (d_tuse_rt),
        .d_wa       (d_wa),
        .d_tnew     (d_tnew),
        .d_md_start (d_md_start),
        .d_md_div   (d_md_div),
        .d_md_use   (d_md_use),
        .flush_req  (flush_req),
        .stall      (stall),
        .pc_en      (pc_en),
        .fd_en      (fd_en),
        .fd_clr     (fd_clr),
        .de_clr     (de_clr),
        .md_busy    (md_busy),
        .e_wa       (e_wa),
        .m_wa       (m_wa),
        .e_tnew     (e_tnew),
        .m_tnew     (m_tnew)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       dv;
        bit [4:0] rs;
        bit [1:0] tus;
        bit [4:0] rt;
        bit [1:0] tut;
        bit [4:0] wa;
        bit [1:0] tn;
        bit       fl;
        bit       ex_stall;
        bit [4:0] ex_ewa;
        bit [1:0] ex_etn;
        bit [4:0] ex_mwa;
        bit [1:0] ex_mtn;
    } vec_t;

    function automatic vec_t mk(bit dv, int rs, int tus, int rt, int tut, int wa, int tn,
                                bit fl, bit es, int ewa, int etn, int mwa, int mtn);
        vec_t v;
        v.dv = dv; v.rs = 5'(rs); v.tus = 2'(tus); v.rt = 5'(rt); v.tut = 2'(tut);
        v.wa = 5'(wa); v.tn = 2'(tn); v.fl = fl; v.ex_stall = es;
        v.ex_ewa = 5'(ewa); v.ex_etn = 2'(etn); v.ex_mwa = 5'(mwa); v.ex_mtn = 2'(mtn);
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, got, exp);
        end
    endtask

    task automatic drv(input bit rst, input bit dv, input int rs, input int tus, input int rt,
                       input int tut, input int wa, input int tn, input bit ms, input bit mdiv,
                       input bit mu, input bit fl);
        reset = rst; d_valid = dv;
        d_rs = 5'(rs); d_tuse_rs = 2'(tus); d_rt = 5'(rt); d_tuse_rt = 2'(tut);
        d_wa = 5'(wa); d_tnew = 2'(tn);
        d_md_start = ms; d_md_div = mdiv; d_md_use = mu; flush_req = fl;
    endtask

    task automatic chk_all(input string tag, input int idx, input bit es, input int ewa,
                           input int etn, input int mwa, input int mtn, input bit busy);
        chk({tag, ".stall"},   idx, 32'(stall),   32'(es));
        chk({tag, ".pc_en"},   idx, 32'(pc_en),   32'(!es));
        chk({tag, ".fd_en"},   idx, 32'(fd_en),   32'(!es));
        chk({tag, ".fd_clr"},  idx, 32'(fd_clr),  32'(flush_req));
        chk({tag, ".de_clr"},  idx, 32'(de_clr),  32'(es | flush_req));
        chk({tag, ".e_wa"},    idx, 32'(e_wa),    32'(ewa));
        chk({tag, ".e_tnew"},  idx, 32'(e_tnew),  32'(etn));
        chk({tag, ".m_wa"},    idx, 32'(m_wa),    32'(mwa));
        chk({tag, ".m_tnew"},  idx, 32'(m_tnew),  32'(mtn));
        chk({tag, ".md_busy"}, idx, 32'(md_busy), 32'(busy));
    endtask

    // Timeline model: each cycle's E entry is remembered; an entry of age k has Tnew max(t-k,0)
    localparam int MAXC = 1700;
    bit rv  [0:MAXC];
    int rwa [0:MAXC];
    int rtn [0:MAXC];
    int m_cyc, m_floor, m_busy_until;

    function automatic bit m_live(int enter);
        return (enter >= 0) && (enter >= m_floor) && rv[enter];
    endfunction

    function automatic int m_left(int enter, int age);
        return (rtn[enter] - age > 0) ? rtn[enter] - age : 0;
    endfunction

    function automatic bit m_hz(int src, int tuse);
        if (src == 0 || tuse == 3) return 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (m_live(m_cyc - k) && rwa[m_cyc - k] == src && m_left(m_cyc - k, k) > tuse)
                return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step(input bit do_check, input int idx);
        bit busy, es, tr;
        int ewa, etn, mwa, mtn, nxt;
        busy = (m_cyc < m_busy_until);
        es   = d_valid && !flush_req &&
               (m_hz(int'(d_rs), int'(d_tuse_rs)) || m_hz(int'(d_rt), int'(d_tuse_rt)) ||
                (d_md_use && busy));
        ewa = 0; etn = 0; mwa = 0; mtn = 0;
        if (m_live(m_cyc))     begin ewa = rwa[m_cyc];     etn = m_left(m_cyc, 0);     end
        if (m_live(m_cyc - 1)) begin mwa = rwa[m_cyc - 1]; mtn = m_left(m_cyc - 1, 1); end
        if (do_check) chk_all("rand", idx, es, ewa, etn, mwa, mtn, busy);
        nxt = m_cyc + 1;
        tr  = d_valid && !es && !flush_req && !reset;
        rv[nxt] = tr; rwa[nxt] = int'(d_wa); rtn[nxt] = int'(d_tnew);
        if (reset) begin
            m_floor = nxt;
            m_busy_until = 0;
        end else if (tr && d_md_start) begin
            m_busy_until = nxt + (d_md_div ? 10 : 5);
        end
        m_cyc = nxt;
    endtask

    vec_t tbl[19];
    int   stall_cnt;

    initial begin
        tbl[0]  = mk(0, 0,3, 0,3, 0,0, 0, 0, 0,0, 0,0);
        tbl[1]  = mk(1, 0,3, 0,3, 1,2, 0, 0, 0,0, 0,0);
        tbl[2]  = mk(1, 1,1, 0,3, 4,1, 0, 1, 1,2, 0,0);
        tbl[3]  = mk(1, 1,1, 0,3, 4,1, 0, 0, 0,0, 1,1);
        tbl[4]  = mk(0, 0,3, 0,3, 0,0, 0, 0, 4,1, 0,0);
        tbl[5]  = mk(1, 0,3, 0,3, 2,1, 0, 0, 0,0, 4,0);
        tbl[6]  = mk(1, 2,0, 5,0, 0,0, 0, 1, 2,1, 0,0);
        tbl[7]  = mk(1, 2,0, 5,0, 0,0, 0, 0, 0,0, 2,0);
        tbl[8]  = mk(1, 0,3, 0,3, 3,2, 0, 0, 0,0, 0,0);
        tbl[9]  = mk(1, 3,0, 3,0, 0,0, 0, 1, 3,2, 0,0);
        tbl[10] = mk(1, 3,0, 3,0, 0,0, 0, 1, 0,0, 3,1);
        tbl[11] = mk(1, 3,0, 3,0, 0,0, 0, 0, 0,0, 0,0);
        tbl[12] = mk(1, 0,3, 0,3, 0,1, 0, 0, 0,0, 0,0);
        tbl[13] = mk(1, 0,1, 0,1, 6,1, 0, 0, 0,1, 0,0);
        tbl[14] = mk(1, 6,3, 6,3, 7,1, 0, 0, 6,1, 0,0);
        tbl[15] = mk(1, 0,3, 0,3, 8,2, 0, 0, 7,1, 6,0);
        tbl[16] = mk(1, 8,1, 0,3, 9,1, 1, 0, 8,2, 7,0);
        tbl[17] = mk(0, 0,3, 0,3, 0,0, 0, 0, 0,0, 8,1);
        tbl[18] = mk(0, 0,3, 0,3, 0,0, 0, 0, 0,0, 0,0);

        drv(1, 0, 0,3, 0,3, 0,0, 0,0,0,0);
        repeat (2) @(posedge clk);

        // Directed table: load-use, ALU->branch, load->branch, $0, unused source, flush
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            drv(0, tbl[i].dv, int'(tbl[i].rs), int'(tbl[i].tus), int'(tbl[i].rt), int'(tbl[i].tut),
                int'(tbl[i].wa), int'(tbl[i].tn), 0, 0, 0, tbl[i].fl);
            @(negedge clk);
            chk_all("vec", i, tbl[i].ex_stall, int'(tbl[i].ex_ewa), int'(tbl[i].ex_etn),
                    int'(tbl[i].ex_mwa), int'(tbl[i].ex_mtn), 1'b0);
        end

        // Mult then div occupancy: mflo held for exactly the unit latency
        for (int u = 0; u < 2; u++) begin
            int lat;
            lat = (u == 0) ? 5 : 10;
            @(posedge clk); #1;
            drv(0, 1, 0,3, 0,3, 0,1, 1, (u == 1), 1, 0);
            @(negedge clk);
            chk("md_issue.stall", u, 32'(stall), 32'(0));
            stall_cnt = 0;
            for (int k = 0; k <= lat; k++) begin
                @(posedge clk); #1;
                drv(0, 1, 0,3, 0,3, 10,1, 0,0,1, 0);
                @(negedge clk);
                chk("md_wait.stall", k, 32'(stall), 32'(k < lat));
                chk("md_wait.busy",  k, 32'(md_busy), 32'(k < lat));
                if (stall) stall_cnt++;
            end
            chk("md_stall_len", u, 32'(stall_cnt), 32'(lat));
        end

        // Reset on the fourth countdown cycle of a divide
        @(posedge clk); #1;
        drv(0, 1, 0,3, 0,3, 0,1, 1,1,1, 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            drv((k == 4), 1, 0,3, 0,3, 10 + k,1, 0,0,0, 0);
            @(negedge clk);
            if (k == 3) chk("div_live.busy", k, 32'(md_busy), 32'(1));
        end
        @(posedge clk); #1;
        drv(0, 1, 0,3, 0,3, 20,1, 0,0,1, 0);
        @(negedge clk);
        chk_all("post_rst", 0, 1'b0, 0,0, 0,0, 1'b0);

        // Randomized traffic against the timeline model, starting from a reset
        m_cyc = 0; m_floor = 0; m_busy_until = 0;
        @(posedge clk); #1;
        drv(1, 0, 0,3, 0,3, 0,0, 0,0,0, 0);
        @(negedge clk);
        model_step(0, 0);
        for (int i = 0; i < 1500; i++) begin
            bit ms;
            @(posedge clk); #1;
            ms = ($urandom_range(0, 7) == 0);
            drv(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2),
                ms, $urandom_range(0, 1), ms | ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 11) == 0));
            @(negedge clk);
            model_step(1, i);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
